// File: rtl/multichan_shift_iir_pkg.sv
// Shared types and width/limit helpers for the multi-channel shift IIR.
package iir_pkg;

    typedef enum logic [1:0] {IDLE, SUB, ACC} state_t;

    // Accumulator: DATAWIDTH integer bits above COEFWIDTH fractional bits.
    function automatic int acc_width(input int dw, input int cw);
        return dw + cw;
    endfunction

    // Width of one per-channel shift field (shift range 0..cw-1).
    function automatic int coef_width(input int cw);
        return (cw > 1) ? $clog2(cw) : 1;
    endfunction

    // Clamp limits of an accumulator of width accw in the given data mode.
    function automatic longint sat_max(input bit sgn, input int accw);
        return sgn ? ((longint'(1) <<< (accw - 1)) - 1) : ((longint'(1) <<< accw) - 1);
    endfunction

    function automatic longint sat_min(input bit sgn, input int accw);
        return sgn ? -(longint'(1) <<< (accw - 1)) : longint'(0);
    endfunction

endpackage

// File: rtl/multichan_shift_iir_if.sv
// Request/result bundle between the sample front end and the filter.
interface iir_if #(
    parameter int NCH       = 4,
    parameter int DATAWIDTH = 16,
    parameter int COEFWIDTH = 16
);
    import iir_pkg::*;

    localparam int CWW = coef_width(COEFWIDTH);

    logic                     start;
    logic                     clr;
    logic [NCH*CWW-1:0]       coef;
    logic [NCH*DATAWIDTH-1:0] x;
    logic [NCH*DATAWIDTH-1:0] yout;
    logic                     busy;
    logic                     done;
    logic [NCH-1:0]           sat;

    modport master (output start, clr, coef, x, input yout, busy, done, sat);
    modport slave  (input start, clr, coef, x, output yout, busy, done, sat);

endinterface

// File: rtl/multichan_shift_iir_shift_step.sv
// Combinational accumulate step: acc + (diff <<< shift), clamped to the acc range.
module iir_shift_step
    import iir_pkg::*;
#(
    parameter  int DATAWIDTH = 16,
    parameter  int COEFWIDTH = 16,
    localparam int ACCW      = acc_width(DATAWIDTH, COEFWIDTH),
    localparam int CWW       = coef_width(COEFWIDTH)
) (
    input  logic [ACCW-1:0]        i_acc,
    input  logic signed [DATAWIDTH:0] i_diff,
    input  logic [CWW-1:0]         i_shift,
    input  logic                   i_signed_mode,
    output logic [ACCW-1:0]        o_acc_next,
    output logic                   o_clamped
);
    // Two guard bits: one for the sign, one so acc + step cannot overflow.
    localparam int EXTW = ACCW + 2;
    localparam logic signed [EXTW-1:0] MAX_S = EXTW'(sat_max(1'b1, ACCW));
    localparam logic signed [EXTW-1:0] MIN_S = EXTW'(sat_min(1'b1, ACCW));
    localparam logic signed [EXTW-1:0] MAX_U = EXTW'(sat_max(1'b0, ACCW));
    localparam logic signed [EXTW-1:0] MIN_U = EXTW'(sat_min(1'b0, ACCW));

    logic signed [EXTW-1:0] w_acc_ext, w_step, w_sum, w_hi, w_lo;

    // Extend, add the shifted difference and clamp to the mode's range.
    always_comb begin
        w_acc_ext  = {{2{i_signed_mode & i_acc[ACCW-1]}}, i_acc};
        w_step     = {{(EXTW-DATAWIDTH-1){i_diff[DATAWIDTH]}}, i_diff} <<< i_shift;
        w_sum      = w_acc_ext + w_step;
        w_hi       = i_signed_mode ? MAX_S : MAX_U;
        w_lo       = i_signed_mode ? MIN_S : MIN_U;
        o_clamped  = 1'b0;
        o_acc_next = w_sum[ACCW-1:0];
        if (w_sum > w_hi) begin
            o_acc_next = w_hi[ACCW-1:0];
            o_clamped  = 1'b1;
        end else if (w_sum < w_lo) begin
            o_acc_next = w_lo[ACCW-1:0];
            o_clamped  = 1'b1;
        end
    end

endmodule

// File: rtl/multichan_shift_iir.sv
// Time-multiplexed first-order shift IIR: one shared datapath, NCH accumulators.
// Each pass visits channels in order with a SUB cycle (difference) and an ACC cycle.
module multichan_shift_iir
    import iir_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int DATAWIDTH = 16,
    parameter int COEFWIDTH = 16,
    parameter int SIGNED    = 0
) (
    input  logic clk,
    input  logic rst_n,
    iir_if.slave bus
);
    localparam int ACCW = acc_width(DATAWIDTH, COEFWIDTH);
    localparam int CWW  = coef_width(COEFWIDTH);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CHW-1:0] LAST_CH = CHW'(NCH - 1);
    localparam logic SGN = (SIGNED != 0);

    state_t                         r_state, w_state_nxt;
    logic [CHW-1:0]                 r_ch;
    logic [NCH-1:0][DATAWIDTH-1:0]  r_x;
    logic [NCH-1:0][CWW-1:0]        r_coef;
    logic [NCH-1:0][ACCW-1:0]       r_acc;
    logic [NCH-1:0]                 r_sat;
    logic signed [DATAWIDTH:0]      r_diff;
    logic                           r_done;

    logic                           w_load, w_acc_en, w_last, w_clamped;
    logic [DATAWIDTH-1:0]           w_x_cur, w_y_cur;
    logic signed [DATAWIDTH:0]      w_x_ext, w_y_ext;
    logic [ACCW-1:0]                w_acc_next;

    // Current-channel operands; the extra bit keeps x - yout from wrapping.
    always_comb begin
        w_last  = (r_ch == LAST_CH);
        w_x_cur = r_x[r_ch];
        w_y_cur = r_acc[r_ch][ACCW-1 -: DATAWIDTH];
        w_x_ext = {SGN & w_x_cur[DATAWIDTH-1], w_x_cur};
        w_y_ext = {SGN & w_y_cur[DATAWIDTH-1], w_y_cur};
    end

    iir_shift_step #(
        .DATAWIDTH (DATAWIDTH),
        .COEFWIDTH (COEFWIDTH)
    ) u_step (
        .i_acc         (r_acc[r_ch]),
        .i_diff        (r_diff),
        .i_shift       (r_coef[r_ch]),
        .i_signed_mode (SGN),
        .o_acc_next    (w_acc_next),
        .o_clamped     (w_clamped)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and per-state strobes; start is only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_acc_en    = 1'b0;
        case (r_state)
            IDLE: if (bus.start) begin
                w_load      = 1'b1;
                w_state_nxt = SUB;
            end
            SUB:  w_state_nxt = ACC;
            ACC: begin
                w_acc_en    = 1'b1;
                w_state_nxt = w_last ? IDLE : SUB;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Snapshot inputs at start, step the channel counter, form the difference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_coef <= '0;
            r_ch   <= '0;
            r_diff <= '0;
            r_done <= 1'b0;
        end else begin
            if (w_load) begin
                r_x    <= bus.x;
                r_coef <= bus.coef;
                r_ch   <= '0;
            end else if (w_acc_en && !w_last) begin
                r_ch   <= r_ch + CHW'(1);
            end
            if (r_state == SUB) r_diff <= w_x_ext - w_y_ext;
            r_done <= w_acc_en && w_last;
        end
    end

    // Accumulators and sticky clamp flags; clr beats the ACC write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_sat <= '0;
        end else if (bus.clr) begin
            r_acc <= '0;
            r_sat <= '0;
        end else if (w_acc_en) begin
            if (r_coef[r_ch] == '0) begin
                r_acc[r_ch] <= '0;
            end else begin
                r_acc[r_ch] <= w_acc_next;
                if (w_clamped) r_sat[r_ch] <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_out
        assign bus.yout[c*DATAWIDTH +: DATAWIDTH] = r_acc[c][ACCW-1 -: DATAWIDTH];
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
    assign bus.sat  = r_sat;

endmodule

// File: tb/tb_multichan_shift_iir.sv
// Directed bench: unsigned and signed filter instances plus the clamp step alone.
module tb_multichan_shift_iir;
    import iir_pkg::*;

    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int CW  = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    iir_if #(.NCH(NCH), .DATAWIDTH(DW), .COEFWIDTH(CW)) bu();
    iir_if #(.NCH(NCH), .DATAWIDTH(DW), .COEFWIDTH(CW)) bs();

    multichan_shift_iir #(.NCH(NCH), .DATAWIDTH(DW), .COEFWIDTH(CW), .SIGNED(0)) u_dut (
        .clk (clk), .rst_n (rst_n), .bus (bu)
    );
    multichan_shift_iir #(.NCH(NCH), .DATAWIDTH(DW), .COEFWIDTH(CW), .SIGNED(1)) s_dut (
        .clk (clk), .rst_n (rst_n), .bus (bs)
    );

    logic [31:0] st_acc;
    logic [16:0] st_diff;
    logic [3:0]  st_shift;
    logic        st_sgn;
    logic [31:0] st_next;
    logic        st_clamp;

    iir_shift_step #(.DATAWIDTH(DW), .COEFWIDTH(CW)) u_step (
        .i_acc (st_acc), .i_diff (st_diff), .i_shift (st_shift), .i_signed_mode (st_sgn),
        .o_acc_next (st_next), .o_clamped (st_clamp)
    );

    typedef struct {
        logic [3:0][3:0]  coef;
        logic [3:0][15:0] x;
        logic [3:0][15:0] y;
    } vec_t;

    typedef struct {
        logic [31:0] acc;
        logic [16:0] diff;
        logic [3:0]  shift;
        logic        sgn;
        logic [31:0] nxt;
        logic        clamp;
    } step_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] yu(input int c);
        return bu.yout[c*DW +: DW];
    endfunction

    function automatic logic [15:0] ys(input int c);
        return bs.yout[c*DW +: DW];
    endfunction

    task automatic clr_u();
        bu.clr = 1'b1;
        tick();
        bu.clr = 1'b0;
    endtask

    // One start pulse, then wait (bounded) for done; lat = edges after the start edge.
    task automatic pass_u(output int lat);
        bu.start = 1'b1;
        tick();
        bu.start = 1'b0;
        lat = 0;
        while (!bu.done && lat < 40) begin
            tick();
            lat++;
        end
        chk("pass_u_done", {63'd0, bu.done}, 64'd1);
    endtask

    task automatic pass_s();
        int n;
        bs.start = 1'b1;
        tick();
        bs.start = 1'b0;
        n = 0;
        while (!bs.done && n < 40) begin
            tick();
            n++;
        end
        chk("pass_s_done", {63'd0, bs.done}, 64'd1);
    endtask

    vec_t  tbl[5];
    step_t stt[7];

    initial begin
        int          lat, n, nd, first, prev, gap_bad, mism, mono_bad;
        longint      m;
        logic [15:0] py;

        tbl[0] = '{coef: {4'd0, 4'd0, 4'd4, 4'd15}, x: {4{16'h8000}},
                   y: {16'h0000, 16'h0000, 16'h0008, 16'h4000}};
        tbl[1] = '{coef: {4{4'd8}}, x: {4{16'h1000}}, y: {4{16'h0010}}};
        tbl[2] = '{coef: {4'd15, 4'd3, 4'd2, 4'd1}, x: {16'h0002, 16'h1234, 16'hFFFF, 16'hFFFF},
                   y: {16'h0001, 16'h0000, 16'h0003, 16'h0001}};
        tbl[3] = '{coef: {4{4'd15}}, x: {16'h0004, 16'h0003, 16'h0002, 16'h0001},
                   y: {16'h0002, 16'h0001, 16'h0001, 16'h0000}};
        tbl[4] = '{coef: {4'd12, 4'd10, 4'd6, 4'd12}, x: {16'h0010, 16'hFFFF, 16'h8001, 16'hABCD},
                   y: {16'h0001, 16'h03FF, 16'h0020, 16'h0ABC}};

        stt[0] = '{32'hFFFFFFF0, 17'h00001, 4'd15, 1'b0, 32'hFFFFFFFF, 1'b1};
        stt[1] = '{32'h00000010, 17'h1FFFF, 4'd15, 1'b0, 32'h00000000, 1'b1};
        stt[2] = '{32'h7FFFFFF0, 17'h00001, 4'd15, 1'b1, 32'h7FFFFFFF, 1'b1};
        stt[3] = '{32'h80000010, 17'h1FFFF, 4'd15, 1'b1, 32'h80000000, 1'b1};
        stt[4] = '{32'h12340000, 17'h00100, 4'd4,  1'b0, 32'h12341000, 1'b0};
        stt[5] = '{32'hFFFF0000, 17'h10000, 4'd15, 1'b1, 32'h80000000, 1'b1};
        stt[6] = '{32'hFFFF0000, 17'h10000, 4'd15, 1'b0, 32'h7FFF0000, 1'b0};

        bu.start = 1'b0; bu.clr = 1'b0; bu.coef = '0; bu.x = '0;
        bs.start = 1'b0; bs.clr = 1'b0; bs.coef = '0; bs.x = '0;
        st_acc = '0; st_diff = '0; st_shift = '0; st_sgn = 1'b0;

        // Reset state.
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        tick(); tick();
        chk("rst_yout", bu.yout, 64'd0);
        chk("rst_busy", {63'd0, bu.busy}, 64'd0);
        chk("rst_done", {63'd0, bu.done}, 64'd0);
        chk("rst_sat",  {60'd0, bu.sat}, 64'd0);
        rst_n = 1'b1;
        tick();

        // Clamp step in isolation (saturation is not reachable through normal passes).
        for (int i = 0; i < 7; i++) begin
            st_acc = stt[i].acc; st_diff = stt[i].diff; st_shift = stt[i].shift; st_sgn = stt[i].sgn;
            #1;
            chk($sformatf("step%0d_next", i), {32'd0, st_next}, {32'd0, stt[i].nxt});
            chk($sformatf("step%0d_clamp", i), {63'd0, st_clamp}, {63'd0, stt[i].clamp});
        end

        // Single passes from a cleared state.
        for (int i = 0; i < 5; i++) begin
            clr_u();
            bu.coef = tbl[i].coef;
            bu.x    = tbl[i].x;
            pass_u(lat);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'd8);
            chk($sformatf("v%0d_busy", i), {63'd0, bu.busy}, 64'd0);
            for (int c = 0; c < NCH; c++)
                chk($sformatf("v%0d_y%0d", i, c), {48'd0, yu(c)}, {48'd0, tbl[i].y[c]});
            chk($sformatf("v%0d_sat", i), {60'd0, bu.sat}, 64'd0);
        end

        // done is a single-cycle pulse.
        tick();
        chk("done_pulse", {63'd0, bu.done}, 64'd0);

        // clr then yout all zero.
        clr_u();
        chk("clr_yout", bu.yout, 64'd0);

        // Busy lasts exactly 2*NCH cycles.
        bu.coef = {4{4'd15}}; bu.x = {4{16'h8000}};
        bu.start = 1'b1;
        tick();
        bu.start = 1'b0;
        n = 0;
        while (bu.busy && n < 40) begin
            n++;
            tick();
        end
        chk("busy_len", 64'(n), 64'd8);

        // start while busy is ignored: exactly one pass happens.
        clr_u();
        bu.start = 1'b1;
        tick();
        bu.start = 1'b0;
        nd = 0;
        for (int k = 0; k < 30; k++) begin
            bu.start = (k == 3);
            tick();
            if (bu.done) nd++;
        end
        bu.start = 1'b0;
        chk("busy_start_dones", 64'(nd), 64'd1);
        chk("busy_start_y0", {48'd0, yu(0)}, 64'h4000);

        // clr landing on ch0's ACC edge wins; the pass and its done continue.
        clr_u();
        bu.start = 1'b1;
        tick();
        bu.start = 1'b0;
        tick();
        bu.clr = 1'b1;
        tick();
        bu.clr = 1'b0;
        n = 0;
        while (!bu.done && n < 40) begin
            tick();
            n++;
        end
        chk("clr_mid_done", {63'd0, bu.done}, 64'd1);
        chk("clr_mid_y0", {48'd0, yu(0)}, 64'h0000);
        chk("clr_mid_y1", {48'd0, yu(1)}, 64'h4000);
        chk("clr_mid_y3", {48'd0, yu(3)}, 64'h4000);

        // coef change mid-pass uses the snapshot; takes effect next pass.
        clr_u();
        bu.start = 1'b1;
        tick();
        bu.start = 1'b0;
        tick(); tick();
        bu.coef[7:4] = 4'd0;
        n = 0;
        while (!bu.done && n < 40) begin
            tick();
            n++;
        end
        chk("snap_y1", {48'd0, yu(1)}, 64'h4000);
        pass_u(lat);
        chk("coef0_y1", {48'd0, yu(1)}, 64'h0000);
        chk("coef0_y0", {48'd0, yu(0)}, 64'h6000);

        // start held high: back-to-back passes, IDLE cycle between (period 2*NCH+1).
        clr_u();
        bu.coef = {4{4'd15}};
        bu.start = 1'b1;
        nd = 0; first = 0; prev = 0; gap_bad = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (bu.done) begin
                if (nd == 0) first = k;
                else if (k - prev != 9) gap_bad++;
                prev = k;
                nd++;
            end
        end
        bu.start = 1'b0;
        chk("b2b_first", 64'(first), 64'd9);
        chk("b2b_count", 64'(nd), 64'd4);
        chk("b2b_gap", 64'(gap_bad), 64'd0);
        n = 0;
        while (bu.busy && n < 40) begin
            tick();
            n++;
        end

        // Convergence against a behavioural model of y += (x - y) / 256.
        clr_u();
        bu.coef = {4{4'd8}}; bu.x = {4{16'h1000}};
        m = 0; mism = 0; mono_bad = 0; py = 16'h0;
        for (int p = 0; p < 200; p++) begin
            pass_u(lat);
            m = m + ((longint'(16'h1000) - (m >>> 16)) <<< 8);
            for (int c = 0; c < NCH; c++)
                if (yu(c) != 16'(m >>> 16)) mism++;
            if (yu(0) < py) mono_bad++;
            py = yu(0);
        end
        chk("conv_model", 64'(mism), 64'd0);
        chk("conv_mono", 64'(mono_bad), 64'd0);
        chk("conv_sat", {60'd0, bu.sat}, 64'd0);

        // Reset mid-pass aborts with no done; the next pass matches a fresh one.
        bu.coef = {4{4'd15}}; bu.x = {4{16'hFFFF}};
        bu.start = 1'b1;
        tick();
        bu.start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_yout", bu.yout, 64'd0);
        chk("mid_rst_busy", {63'd0, bu.busy}, 64'd0);
        chk("mid_rst_done", {63'd0, bu.done}, 64'd0);
        tick(); tick();
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bu.done) nd++;
        end
        chk("mid_rst_nodone", 64'(nd), 64'd0);
        bu.coef = tbl[0].coef; bu.x = tbl[0].x;
        pass_u(lat);
        for (int c = 0; c < NCH; c++)
            chk($sformatf("post_rst_y%0d", c), {48'd0, yu(c)}, {48'd0, tbl[0].y[c]});

        // Signed: settle at +32767, then step to -32768 without wrapping.
        bs.coef = {4{4'd15}}; bs.x = {4{16'h7FFF}};
        for (int p = 0; p < 40; p++) pass_s();
        for (int c = 0; c < NCH; c++)
            chk($sformatf("s_settle_y%0d", c), {48'd0, ys(c)}, 64'h7FFF);
        bs.x = {4{16'h8000}};
        pass_s();
        chk("s_step1_y0", {48'd0, ys(0)}, 64'hFFFF);
        chk("s_step1_y2", {48'd0, ys(2)}, 64'hFFFF);
        for (int p = 0; p < 40; p++) pass_s();
        for (int c = 0; c < NCH; c++)
            chk($sformatf("s_neg_y%0d", c), {48'd0, ys(c)}, 64'h8000);
        chk("s_sat", {60'd0, bs.sat}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
